// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter for one shared 4:1 output lane.
// The grant is registered, with a matching 2-bit select and a one-hot grant
// returned to the requesters. The winner's lane is steered to data_out.
// Optional build macro ARB_TIMEOUT_EN adds a hold counter. Under contention
// it limits one grant to MAX_HOLD consecutive cycles.

// Per-lane gate: passes the lane's data only while that lane holds the grant
module mux4_rr_lane #(
  parameter int DATA_W = 1
) (
  input  logic              gnt,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  assign dout = {DATA_W{gnt}} & din;
endmodule

module mux4_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   data_in,
  output logic [3:0]            grant,
  output logic [1:0]            sel,
  output logic                  valid,
  output logic [DATA_W-1:0]     data_out
);
  localparam int NUM_LANES = 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Catch an out-of-range hold bound at elaboration, whether or not the timeout is built
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  logic [0:0] state, state_nx;
  logic [1:0] ptr, ptr_nx, sel_nx, win;
  logic [3:0] others;
  logic       load, tmo;

  // First set request scanning upward from p, wrapping mod 4
  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Requests other than the current owner. A handoff from GRANT only ever goes to one of these.
  assign others = req & ~(4'b0001 << sel);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // Count cycles spent on the current grant. Restart on each new grant. Stick at the last slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   hold_cnt <= '0;
    else if (load)                               hold_cnt <= '0;
    else if (state == GRANT && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 8'd1;
  end

  assign tmo = (state == GRANT) && (hold_cnt == HOLD_LAST) && (|others);
`else
  assign tmo = 1'b0;
`endif

  // Choose the next owner. Handoff happens on release or timeout, with no idle bubble.
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    ptr_nx   = ptr;
    load     = 1'b0;
    win      = 2'b00;
    case (state)
      IDLE: begin
        if (|req) begin
          load = 1'b1;
          win  = rr_pick(ptr, req);
        end
      end
      default: begin
        if (!req[sel] || tmo) begin
          if (|others) begin
            load = 1'b1;
            win  = rr_pick(ptr, others);
          end else begin
            state_nx = IDLE;
          end
        end
      end
    endcase
    if (load) begin
      state_nx = GRANT;
      sel_nx   = win;
      ptr_nx   = win + 2'd1;
    end
  end

  // Register state, select, pointer and the one-hot grant derived from the next select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= 2'b00;
      ptr   <= 2'b00;
      grant <= 4'b0000;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      ptr   <= ptr_nx;
      grant <= (state_nx == GRANT) ? (4'b0001 << sel_nx) : 4'b0000;
    end
  end

  assign valid = (state == GRANT);

  // Grant equals the decode of sel while valid and is zero otherwise, so gating lanes by grant gives the mux
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_data, lane_gated;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_data[i] = data_in[i*DATA_W +: DATA_W];
    mux4_rr_lane #(.DATA_W(DATA_W)) u_lane (
      .gnt  (grant[i]),
      .din  (lane_data[i]),
      .dout (lane_gated[i])
    );
  end

  // OR the gated lanes together. At most one of them is non-zero.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_LANES; i++) data_out = data_out | lane_gated[i];
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (DATA_W=1, MAX_HOLD=4).
// Expected values are hand-computed. The hold-limit expectations depend on ARB_TIMEOUT_EN.
module tb_mux4_rr_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] data_in;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;
  logic [0:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  mux4_rr_arbiter #(.DATA_W(1), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
    .grant    (grant),
    .sel      (sel),
    .valid    (valid),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check grant, sel, valid and data_out in one call
  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic v, input logic d);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".sel"},   32'(sel),   32'(s));
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".dout"},  32'(data_out), 32'(d));
  endtask

  logic [3:0] exp_g;
  logic       exp_d;

  initial begin
    reset   = 1'b1;
    req     = 4'b0000;
    data_in = 4'b0101;
    #3;
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Idle: no requests, so all outputs stay zero
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // One-clock grant latency, then a back-to-back handoff
    req = 4'b1010;
    tick();
    chk_all("t2_first", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    chk_all("t2_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1000;
    tick();
    chk_all("t2_handoff", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk_all("t2_idle_keep_sel", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Rotation 0,1,2,3,0. ptr wrapped to 0. Each winner drops its request after one granted cycle.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_g = 4'b0001 << (i % 4);
      exp_d = ((i % 2) == 0);
      chk_all("t3_rr", exp_g, 2'(i % 4), 1'b1, exp_d);
      req = ~exp_g;
    end

    // Reach grant 0100, then assert reset between edges
    req = 4'b0100;
    tick();
    chk_all("t4_pre", 4'b0100, 2'd2, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("t4_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1100;
    tick();
    chk_all("t4_in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("t4_after", 4'b0100, 2'd2, 1'b1, 1'b1);

    // Hold limit: requests 0 and 1 held together
    req = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      tick();
`ifdef ARB_TIMEOUT_EN
      exp_g = (((k / 4) % 2) == 1) ? 4'b0010 : 4'b0001;
`else
      exp_g = 4'b0001;
`endif
      chk("t5_hold", 32'(grant), 32'(exp_g));
    end

    // Lone requester keeps its grant (counter sits at its last slot)
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_alone", 32'(grant), 32'(4'b0001));
    end
    // Contention returns. A saturated counter forces the switch on the very next edge.
    req = 4'b0011;
    tick();
`ifdef ARB_TIMEOUT_EN
    exp_g = 4'b0010;
`else
    exp_g = 4'b0001;
`endif
    chk("t5_sat_switch", 32'(grant), 32'(exp_g));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
